// File: rtl/plru_pkg.sv
//------------------------------------------------------------------------------
// Module  : plru_pkg
// Brief   : Shared constants, types and the tree-PLRU touch function.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package plru_pkg;

    localparam int WAYS     = 8;
    localparam int WAYS_REP = 3;
    localparam int PLRU_W   = WAYS - 1;

    typedef logic [PLRU_W-1:0]   plru_t;
    typedef logic [WAYS_REP-1:0] way_t;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Point every node on the accessed way's path toward the opposite subtree.
    function automatic plru_t plru_touch(plru_t cur, way_t way);
        plru_t nxt;
        nxt    = cur;
        nxt[0] = ~way[2];
        if (!way[2]) begin
            nxt[1] = ~way[1];
            if (way[1]) nxt[4] = ~way[0];
            else        nxt[3] = ~way[0];
        end else begin
            nxt[2] = ~way[1];
            if (way[1]) nxt[6] = ~way[0];
            else        nxt[5] = ~way[0];
        end
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/plru_array.sv
//------------------------------------------------------------------------------
// Module  : plru_array
// Brief   : SETS x 7 storage, one write port, one registered read port.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module plru_array
    import plru_pkg::*;
#(
    parameter int SETS  = 16384,
    parameter int INDEX = 14
) (
    input  logic              clk,
    input  logic              we,
    input  logic [INDEX-1:0]  waddr,
    input  logic [PLRU_W-1:0] wdata,
    input  logic              re,
    input  logic [INDEX-1:0]  raddr,
    output logic [PLRU_W-1:0] rdata
);

    plru_t r_mem [SETS];
    plru_t r_rdata;

    // Read-before-write on an address collision; the top forwards around it.
    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
        if (re) r_rdata <= r_mem[raddr];
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/plru_update.sv
//------------------------------------------------------------------------------
// Module  : plru_update
// Brief   : Tree-PLRU state writer with clear sweep, 2-stage update pipeline
//           and registered read port. Optional PLRU_STATS_EN adds upd_count.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module plru_update
    import plru_pkg::*;
#(
    parameter int SETS  = 16384,
    parameter int INDEX = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                plru_clr,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic [INDEX-1:0]    upd_set,
    input  logic [WAYS_REP-1:0] upd_way,
    output logic                upd_done,
    output logic [PLRU_W-1:0]   upd_lru_new,
    input  logic                rd_en,
    input  logic [INDEX-1:0]    rd_set,
    output logic [PLRU_W-1:0]   rd_lru,
    output logic                init_busy
`ifdef PLRU_STATS_EN
    ,
    output logic [31:0]         upd_count
`endif
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [INDEX-1:0] r_sweep_cnt;
    logic [INDEX-1:0] w_sweep_nxt;

    logic             r_s1_valid;
    logic [INDEX-1:0] r_s1_set;
    way_t             r_s1_way;
    logic             r_fwd_hit;
    plru_t            r_fwd_data;

    logic             r_done;
    plru_t            r_lru_new;

    logic             r_rd_zero;
    logic             r_rd_fwd;
    plru_t            r_rd_fwd_data;

    logic             w_accept;
    logic             w_commit;
    plru_t            w_cur;
    plru_t            w_new;
    plru_t            w_upd_q;
    plru_t            w_rd_q;
    logic             w_we;
    logic [INDEX-1:0] w_waddr;
    plru_t            w_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INIT;
            r_sweep_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_cnt <= w_sweep_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep_cnt;
        upd_ready   = 1'b0;
        init_busy   = 1'b1;
        case (r_state)
            INIT: begin
                if (r_sweep_cnt == INDEX'(SETS - 1)) w_state_nxt = RUN;
                else                                 w_sweep_nxt = r_sweep_cnt + 1'b1;
            end
            RUN: begin
                upd_ready = 1'b1;
                init_busy = 1'b0;
            end
            default: w_state_nxt = INIT;
        endcase
        if (plru_clr) begin
            w_state_nxt = INIT;
            w_sweep_nxt = '0;
        end
    end

    assign w_accept = upd_valid & upd_ready;
    // A clear kills the stage-1 update before it reaches the array.
    assign w_commit = r_s1_valid & ~plru_clr;
    assign w_cur    = r_fwd_hit ? r_fwd_data : w_upd_q;
    assign w_new    = plru_touch(w_cur, r_s1_way);

    assign w_we     = (r_state == INIT) | w_commit;
    assign w_waddr  = (r_state == INIT) ? r_sweep_cnt : r_s1_set;
    assign w_wdata  = (r_state == INIT) ? plru_t'(0) : w_new;

    // Replicated storage gives the update path and the read port their own read.
    plru_array #(.SETS(SETS), .INDEX(INDEX)) u_arr_upd (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .re    (w_accept),
        .raddr (upd_set),
        .rdata (w_upd_q)
    );

    plru_array #(.SETS(SETS), .INDEX(INDEX)) u_arr_rd (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .re    (rd_en),
        .raddr (rd_set),
        .rdata (w_rd_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_set      <= '0;
            r_s1_way      <= '0;
            r_fwd_hit     <= 1'b0;
            r_fwd_data    <= '0;
            r_done        <= 1'b0;
            r_lru_new     <= '0;
            r_rd_zero     <= 1'b1;
            r_rd_fwd      <= 1'b0;
            r_rd_fwd_data <= '0;
        end else begin
            r_s1_valid <= w_accept & ~plru_clr;
            if (w_accept) begin
                r_s1_set   <= upd_set;
                r_s1_way   <= upd_way;
                r_fwd_hit  <= w_commit && (upd_set == r_s1_set);
                r_fwd_data <= w_new;
            end
            r_done <= w_commit;
            if (w_commit) r_lru_new <= w_new;
            if (rd_en) begin
                r_rd_zero     <= (r_state == INIT) | plru_clr;
                r_rd_fwd      <= w_commit && (rd_set == r_s1_set);
                r_rd_fwd_data <= w_new;
            end
        end
    end

    assign upd_done    = r_done;
    assign upd_lru_new = r_lru_new;
    assign rd_lru      = r_rd_zero ? plru_t'(0) : (r_rd_fwd ? r_rd_fwd_data : w_rd_q);

`ifdef PLRU_STATS_EN
    logic [31:0] r_upd_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_count <= '0;
        end else if (plru_clr) begin
            r_upd_count <= '0;
        end else if (w_commit && (r_upd_count != 32'hFFFF_FFFF)) begin
            r_upd_count <= r_upd_count + 32'd1;
        end
    end

    assign upd_count = r_upd_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_plru_update.sv
//------------------------------------------------------------------------------
// Module  : tb_plru_update
// Brief   : Randomized self-checking bench for plru_update against a tree model.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_plru_update;

    localparam int SETS  = 16384;
    localparam int INDEX = 14;

    logic             clk;
    logic             rst_n;
    logic             plru_clr;
    logic             upd_valid;
    logic             upd_ready;
    logic [INDEX-1:0] upd_set;
    logic [2:0]       upd_way;
    logic             upd_done;
    logic [6:0]       upd_lru_new;
    logic             rd_en;
    logic [INDEX-1:0] rd_set;
    logic [6:0]       rd_lru;
    logic             init_busy;
`ifdef PLRU_STATS_EN
    logic [31:0]      upd_count;
`endif

    plru_update #(.SETS(SETS), .INDEX(INDEX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .plru_clr    (plru_clr),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_set     (upd_set),
        .upd_way     (upd_way),
        .upd_done    (upd_done),
        .upd_lru_new (upd_lru_new),
        .rd_en       (rd_en),
        .rd_set      (rd_set),
        .rd_lru      (rd_lru),
        .init_busy   (init_busy)
`ifdef PLRU_STATS_EN
        ,
        .upd_count   (upd_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec;
    int         n_err;
    logic [6:0] m_mem [SETS];
    bit         exp_busy;
    int         sweep_left;
    bit         pend_v;
    int         pend_set;
    int         pend_way;
    bit         exp_done;
    logic [6:0] exp_lru_new;
    logic [6:0] exp_rd;
    bit         rd_known;
    longint     exp_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Heap-ordered binary tree: node n has children 2n+1 / 2n+2.
    function automatic logic [6:0] tree_touch(logic [6:0] v, int w);
        logic [6:0] r;
        int n;
        r = v;
        n = 0;
        for (int lvl = 0; lvl < 3; lvl++) begin
            int b;
            b    = (w >> (2 - lvl)) & 1;
            r[n] = (b == 0);
            n    = 2 * n + 1 + b;
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) m_mem[i] = 7'h00;
    endtask

    task automatic model_reset();
        model_clear();
        exp_busy   = 1'b1;
        sweep_left = SETS;
        pend_v     = 1'b0;
        exp_done   = 1'b0;
        exp_rd     = 7'h00;
        rd_known   = 1'b1;
        exp_cnt    = 0;
    endtask

    // Called at a negedge: drive, advance one edge in DUT and model, then check.
    task automatic cycle(input bit v, input int set, input int way,
                         input bit rd, input int rset, input bit clr);
        bit accept;
        bit commit;
        upd_valid = v;
        upd_set   = INDEX'(set);
        upd_way   = 3'(way);
        rd_en     = rd;
        rd_set    = INDEX'(rset);
        plru_clr  = clr;
        @(posedge clk);
        accept = v && !exp_busy;
        commit = pend_v && !clr;
        if (commit) begin
            m_mem[pend_set] = tree_touch(m_mem[pend_set], pend_way);
            exp_lru_new     = m_mem[pend_set];
            exp_cnt++;
        end
        exp_done = commit;
        if (rd) begin
            exp_rd   = (exp_busy || clr) ? 7'h00 : m_mem[rset];
            rd_known = 1'b1;
        end else if (clr) begin
            rd_known = 1'b0;
        end
        pend_v   = accept && !clr;
        pend_set = set;
        pend_way = way;
        if (clr) begin
            exp_busy   = 1'b1;
            sweep_left = SETS;
            exp_cnt    = 0;
            model_clear();
        end else if (exp_busy) begin
            sweep_left--;
            if (sweep_left == 0) exp_busy = 1'b0;
        end
        @(negedge clk);
        chk("upd_ready", upd_ready, !exp_busy);
        chk("init_busy", init_busy, exp_busy);
        chk("upd_done", upd_done, exp_done);
        if (exp_done) chk("upd_lru_new", upd_lru_new, exp_lru_new);
        if (rd_known) chk("rd_lru", rd_lru, exp_rd);
`ifdef PLRU_STATS_EN
        chk("upd_count", upd_count, 32'(exp_cnt));
`endif
    endtask

    task automatic idle();
        cycle(1'b0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic upd(input int set, input int way);
        cycle(1'b1, set, way, 1'b0, 0, 1'b0);
    endtask

    task automatic rd(input int set);
        cycle(1'b0, 0, 0, 1'b1, set, 1'b0);
    endtask

    task automatic run_sweep();
        int guard;
        guard = 0;
        while (exp_busy && guard < SETS + 10) begin
            idle();
            guard++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, upd_ready, 1'b0);
        chk({tag, "_done"}, upd_done, 1'b0);
        chk({tag, "_lru_new"}, upd_lru_new, 7'h00);
        chk({tag, "_rd_lru"}, rd_lru, 7'h00);
        chk({tag, "_busy"}, init_busy, 1'b1);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        plru_clr  = 1'b0;
        upd_valid = 1'b0;
        upd_set   = '0;
        upd_way   = '0;
        rd_en     = 1'b0;
        rd_set    = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        run_sweep();
        rd(5);
        chk("set5_zero", rd_lru, 7'h00);

        upd(3, 0);
        idle();
        chk("way0_vec", upd_lru_new, 7'h0B);
        rd(3);
        chk("set3_read", rd_lru, 7'h0B);

        upd(7, 0);
        upd(7, 5);
        idle();
        rd(7);

        for (int w = 0; w < 8; w++) upd(9, w);
        idle();
        rd(9);
        chk("set9_all_ways", rd_lru, 7'h00);

        // Mixed traffic over a few sets so forwarding paths are hit often.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 4) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom % 2, $urandom_range(0, 7), 1'b0);
        end
        idle();
        idle();

        upd(2, 1);
        cycle(1'b0, 0, 0, 1'b1, 2, 1'b1);
        run_sweep();
        rd(2);
        chk("set2_cleared", rd_lru, 7'h00);
        for (int i = 0; i < 200; i++) begin
            cycle(($urandom % 2) != 0, $urandom_range(0, 3), $urandom_range(0, 7),
                  $urandom % 2, $urandom_range(0, 3), 1'b0);
        end

        cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
        repeat (100) idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep();
        upd(4, 6);
        idle();
        rd(4);
        chk("post_reset_upd", rd_lru, tree_touch(7'h00, 6));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
